// File: rtl/rd53_cmd_ser.sv
// RD53A command serializer: 16-bit frames out MSB-first, with a periodic sync and NOOP idle fill.
// Optional statistics counters are compiled in when RD53_CMD_STATS_EN is defined.
module rd53_cmd_ser #(
    parameter int          SYNC_PERIOD = 32,
    parameter logic [15:0] SYNC_WORD   = 16'h817E,
    parameter logic [15:0] NOOP_WORD   = 16'h6969
) (
    input  logic        clk160MHz,
    input  logic        rst160MHz,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        cmd_out,
    output logic        frame_start,
    output logic        sync_sent
`ifdef RD53_CMD_STATS_EN
    ,
    input  logic        stat_clr,
    output logic [31:0] stat_user_cnt,
    output logic [31:0] stat_sync_cnt,
    output logic [31:0] stat_noop_cnt
`endif
);

    localparam int              SLOT_W    = (SYNC_PERIOD > 2) ? $clog2(SYNC_PERIOD) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SYNC_PERIOD - 1);

    logic [3:0]        bit_cnt_r;
    logic [SLOT_W-1:0] slot_cnt_r;
    logic [15:0]       shreg_r;
    logic              load_s;
    logic              is_sync_s;
    logic              accept_s;
    logic              is_noop_s;
    logic [15:0]       word_s;

    // Load decision and word selection: sync slot first, then user frame, else idle fill
    always_comb begin
        load_s    = (bit_cnt_r == 4'd15);
        is_sync_s = load_s && (slot_cnt_r == '0);
        s_ready   = load_s && (slot_cnt_r != '0) && !rst160MHz;
        accept_s  = s_ready && s_valid;
        is_noop_s = load_s && !is_sync_s && !accept_s;
        if (is_sync_s) begin
            word_s = SYNC_WORD;
        end else if (accept_s) begin
            word_s = s_data;
        end else begin
            word_s = NOOP_WORD;
        end
    end

    // Bit/slot counters, shift register and registered serial outputs
    always_ff @(posedge clk160MHz) begin
        if (rst160MHz) begin
            bit_cnt_r   <= 4'd15;
            slot_cnt_r  <= '0;
            shreg_r     <= 16'h0000;
            cmd_out     <= 1'b0;
            frame_start <= 1'b0;
            sync_sent   <= 1'b0;
        end else begin
            bit_cnt_r   <= bit_cnt_r - 4'd1;
            frame_start <= load_s;
            sync_sent   <= is_sync_s;
            if (load_s) begin
                // cmd_out takes bit 15 straight from the selected word so it lands one cycle after the load
                shreg_r    <= word_s;
                cmd_out    <= word_s[15];
                slot_cnt_r <= (slot_cnt_r == SLOT_LAST) ? '0 : slot_cnt_r + {{(SLOT_W-1){1'b0}}, 1'b1};
            end else begin
                shreg_r    <= {shreg_r[14:0], 1'b0};
                cmd_out    <= shreg_r[14];
                slot_cnt_r <= slot_cnt_r;
            end
        end
    end

`ifdef RD53_CMD_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating per-kind frame counters; clear wins over increment
    always_ff @(posedge clk160MHz) begin
        if (rst160MHz || stat_clr) begin
            stat_user_cnt <= 32'd0;
            stat_sync_cnt <= 32'd0;
            stat_noop_cnt <= 32'd0;
        end else begin
            stat_user_cnt <= accept_s  ? sat_inc(stat_user_cnt) : stat_user_cnt;
            stat_sync_cnt <= is_sync_s ? sat_inc(stat_sync_cnt) : stat_sync_cnt;
            stat_noop_cnt <= is_noop_s ? sat_inc(stat_noop_cnt) : stat_noop_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_rd53_cmd_ser.sv
// Directed bench for rd53_cmd_ser: sync cadence, NOOP fill, handshake latency, reset abort, stats.
module tb_rd53_cmd_ser;

    logic        clk160MHz = 1'b0;
    logic        rst160MHz = 1'b1;
    logic [15:0] s_data    = 16'h0000;
    logic        s_valid   = 1'b0;
    logic        s_ready;
    logic        cmd_out;
    logic        frame_start;
    logic        sync_sent;
`ifdef RD53_CMD_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] stat_user_cnt;
    logic [31:0] stat_sync_cnt;
    logic [31:0] stat_noop_cnt;
`endif

    rd53_cmd_ser dut (
        .clk160MHz   (clk160MHz),
        .rst160MHz   (rst160MHz),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .cmd_out     (cmd_out),
        .frame_start (frame_start),
        .sync_sent   (sync_sent)
`ifdef RD53_CMD_STATS_EN
        ,
        .stat_clr      (stat_clr),
        .stat_user_cnt (stat_user_cnt),
        .stat_sync_cnt (stat_sync_cnt),
        .stat_noop_cnt (stat_noop_cnt)
`endif
    );

    always #4 clk160MHz = ~clk160MHz;

    int          vecs = 0;
    int          errs = 0;
    int          cyc  = 0;
    logic        cmd_log [0:2047];
    logic        fs_log  [0:2047];
    logic        ss_log  [0:2047];
    logic        rdy_log [0:2047];
    logic [15:0] q [$];

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sample();
        cmd_log[cyc] = cmd_out;
        fs_log[cyc]  = frame_start;
        ss_log[cyc]  = sync_sent;
        rdy_log[cyc] = s_ready;
    endtask

    task automatic drive();
        s_valid = (q.size() != 0);
        s_data  = (q.size() != 0) ? q[0] : 16'h0000;
    endtask

    // one clock: detect the handshake the edge will take, then advance the source queue
    task automatic tick();
        logic hs;
        #1;
        hs = s_valid && s_ready;
        @(posedge clk160MHz);
        #1;
        if (hs) void'(q.pop_front());
        drive();
        cyc++;
        #1;
        sample();
    endtask

    task automatic do_reset();
        rst160MHz = 1'b1;
        repeat (3) @(posedge clk160MHz);
        #1;
        rst160MHz = 1'b0;
        drive();
        cyc = 0;
        #1;
        sample();
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    function automatic logic [15:0] word_at(input int s);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[15-i] = cmd_log[s+i];
        return w;
    endfunction

    function automatic int count_set(input int sel, input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) begin
            if (sel == 0 && fs_log[i])  n++;
            if (sel == 1 && ss_log[i])  n++;
            if (sel == 2 && rdy_log[i]) n++;
        end
        return n;
    endfunction

    initial begin
        logic [15:0] exp_w;
        int          f;

        // reset state
        q.delete();
        rst160MHz = 1'b1;
        repeat (3) @(posedge clk160MHz);
        #1;
        check_vec("rst_cmd_out", {31'd0, cmd_out}, 32'd0);
        check_vec("rst_ready",   {31'd0, s_ready}, 32'd0);
        check_vec("rst_fstart",  {31'd0, frame_start}, 32'd0);
        check_vec("rst_sync",    {31'd0, sync_sent}, 32'd0);

        // idle: one sync then NOOP fill
        do_reset();
        run_to(64);
        check_vec("idle_w1", {16'd0, word_at(1)},  32'h817E);
        check_vec("idle_w2", {16'd0, word_at(17)}, 32'h6969);
        check_vec("idle_w3", {16'd0, word_at(33)}, 32'h6969);
        check_vec("idle_w4", {16'd0, word_at(49)}, 32'h6969);
        check_vec("idle_fs_cnt", count_set(0, 0, 64), 32'd4);
        check_vec("idle_fs_pos", {28'd0, fs_log[1], fs_log[17], fs_log[33], fs_log[49]}, 32'hF);
        check_vec("idle_ss_cnt", count_set(1, 0, 64), 32'd1);
        check_vec("idle_ss_pos", {31'd0, ss_log[1]}, 32'd1);
        check_vec("idle_rdy_cnt", count_set(2, 0, 63), 32'd3);
        check_vec("idle_rdy16", {31'd0, rdy_log[16]}, 32'd1);

        // single frame held from reset waits out the sync slot
        q.delete();
        q.push_back(16'h5A5A);
        do_reset();
        run_to(40);
        check_vec("one_rdy_cnt", count_set(2, 0, 16), 32'd1);
        check_vec("one_rdy16",   {31'd0, rdy_log[16]}, 32'd1);
        check_vec("one_word",    {16'd0, word_at(17)}, 32'h5A5A);
        check_vec("one_fs17",    {31'd0, fs_log[17]}, 32'd1);
        check_vec("one_ss17",    {31'd0, ss_log[17]}, 32'd0);
        check_vec("one_drained", q.size(), 32'd0);

        // 40 back-to-back frames straddling the second sync
        q.delete();
        for (int i = 1; i <= 40; i++) q.push_back(16'(i));
        do_reset();
        run_to(16 * 42 + 1);
        f = 1;
        for (int s = 0; s < 42; s++) begin
            if (s == 0 || s == 32) begin
                exp_w = 16'h817E;
            end else begin
                exp_w = 16'(f);
                f++;
            end
            check_vec($sformatf("strm_slot%0d", s), {16'd0, word_at(16 * s + 1)}, {16'd0, exp_w});
        end
        check_vec("strm_ss_cnt", count_set(1, 0, 16 * 42), 32'd2);
        check_vec("strm_ss513",  {31'd0, ss_log[513]}, 32'd1);

        // reset at bit 7 of a user frame aborts it without resend
        q.delete();
        q.push_back(16'hFFFF);
        q.push_back(16'hC3A5);
        do_reset();
        run_to(25);
        check_vec("abort_bit7", {31'd0, cmd_log[25]}, 32'd1);
        rst160MHz = 1'b1;
        tick();
        check_vec("abort_cmd0",  {31'd0, cmd_out}, 32'd0);
        check_vec("abort_rdy0",  {31'd0, s_ready}, 32'd0);
        rst160MHz = 1'b0;
        drive();
        cyc = 0;
        #1;
        sample();
        run_to(40);
        check_vec("abort_sync",  {16'd0, word_at(1)},  32'h817E);
        check_vec("abort_ss1",   {31'd0, ss_log[1]}, 32'd1);
        check_vec("abort_next",  {16'd0, word_at(17)}, 32'hC3A5);

        // user frame equal to the sync symbol
        q.delete();
        q.push_back(16'h817E);
        do_reset();
        run_to(16 * 33 + 1);
        check_vec("usync_word", {16'd0, word_at(17)}, 32'h817E);
        check_vec("usync_ss17", {31'd0, ss_log[17]}, 32'd0);
        check_vec("usync_fs17", {31'd0, fs_log[17]}, 32'd1);
        check_vec("usync_auto", {16'd0, word_at(513)}, 32'h817E);
        check_vec("usync_ss513", {31'd0, ss_log[513]}, 32'd1);
        check_vec("usync_sscnt", count_set(1, 0, 16 * 33), 32'd2);

`ifdef RD53_CMD_STATS_EN
        q.delete();
        for (int i = 0; i < 10; i++) q.push_back(16'h1000 + 16'(i));
        do_reset();
        check_vec("stat_rst_user", stat_user_cnt, 32'd0);
        run_to(1010);
        check_vec("stat_user", stat_user_cnt, 32'd10);
        check_vec("stat_sync", stat_sync_cnt, 32'd2);
        check_vec("stat_noop", stat_noop_cnt, 32'd52);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check_vec("stat_clr_user", stat_user_cnt, 32'd0);
        check_vec("stat_clr_sync", stat_sync_cnt, 32'd0);
        check_vec("stat_clr_noop", stat_noop_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/rd53_cmd_ser.md
Name: rd53_cmd_ser

Overview:
- Upstream command-stream generator for the RD53A front end.
- Takes 16-bit command frames from the FEB command logic over a valid/ready handshake and serializes them MSB-first at 1 bit per clk160MHz cycle. The serial bit goes onto the chip CMD_P/CMD_N pad pair.
- Automatically inserts the RD53A sync symbol every SYNC_PERIOD frames and fills idle slots with NOOP symbols, so the chip CDR and frame alignment stay locked.

Parameters:
- SYNC_PERIOD, 32: frame slots per sync interval; exactly one slot in each interval is a sync symbol. Legal range 2..256.
- SYNC_WORD, 16'h817E: sync symbol.
- NOOP_WORD, 16'h6969: idle-fill symbol.

Ports:
- clk160MHz  in  1  single clock; one serial bit per cycle.
- rst160MHz  in  1  synchronous, active-high reset.
- s_data  in  16  command frame; bit 15 is transmitted first.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  frame slot open; a frame is accepted on a cycle where s_valid && s_ready.
- cmd_out  out  1  serial command bit to the pad driver (registered).
- frame_start  out  1  one-cycle pulse on the cycle cmd_out carries bit 15 of any frame.
- sync_sent  out  1  one-cycle pulse coincident with frame_start when that frame is SYNC_WORD.

Behaviour:
- Reset values:
  - shreg = 16'h0000, cmd_out = 0, bit_cnt = 15, slot_cnt = 0.
  - s_ready = 0, frame_start = 0, sync_sent = 0.
- bit_cnt counts 15 down to 0, decrementing each cycle and wrapping from 0 to 15. A "load edge" is any clock edge where bit_cnt == 0, or the first edge after reset release (bit_cnt == 15 with the post-reset flag set).
- Simplification: a load edge occurs when bit_cnt == 15 at the start of the cycle. The 16-cycle slot is defined as the cycles spent with bit_cnt = 15..0.
- cmd_out = shreg[15] (registered). shreg shifts left by 1 every cycle, except on load edges, where it loads the selected word.
- Word selection at a load edge, in priority order:
  1. slot_cnt == 0: load SYNC_WORD.
  2. else if s_valid: load s_data, and the handshake completes.
  3. else: load NOOP_WORD.
- slot_cnt increments on every load edge and wraps from SYNC_PERIOD-1 to 0.
- s_ready is combinational: (bit_cnt == 15) && (slot_cnt != 0) && !rst160MHz. It is high for exactly one cycle per non-sync slot. s_data must be held until accepted; s_valid may be held across any number of slots.
- Latency: a frame accepted in cycle t has bit 15 on cmd_out in cycle t+1 and bit 0 in cycle t+16. A back-to-back accept happens in cycle t+16.
- frame_start and sync_sent are registered from the load decision, so they align with bit 15 on cmd_out.
- Boundary conditions:
  - s_valid arriving during the sync slot is not accepted; it waits one full slot (16 cycles).
  - s_valid deasserted mid-slot has no effect, because sampling happens only at the load edge.
  - Reset mid-frame aborts the frame immediately: cmd_out goes to 0 the cycle after reset is sampled. The first slot after reset release is always a sync.
  - s_data == SYNC_WORD from the user is transmitted unchanged but does not assert sync_sent and does not affect slot_cnt.

Optional Feature:
- RD53_CMD_STATS_EN
- Defined: three extra output ports, each 32 bits:
  - stat_user_cnt: accepted user frames.
  - stat_sync_cnt: sync symbols sent.
  - stat_noop_cnt: NOOP symbols sent.
  - Each counter increments at its load edge and saturates at 32'hFFFFFFFF.
  - A clear input stat_clr (1 bit) zeroes all three counters synchronously, with priority over increment. All counters reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset release, s_valid=0 for 64 cycles -> cmd_out carries 0x817E in cycles 1-16, then 0x6969 ×3. sync_sent pulses at cycle 1 only; frame_start pulses at cycles 1, 17, 33, 49.
- s_valid=1, s_data=0x5A5A held from reset -> accepted at cycle 16 (first non-sync slot). Bits 0x5A5A appear MSB-first in cycles 17-32, and s_ready is high only at cycle 16.
- Stream of 40 frames 0x0001..0x0028, s_valid always high, SYNC_PERIOD=32 -> exactly one 0x817E precedes frame 0x0001. A second 0x817E appears after frame 0x001F, and frame 0x0020 follows it. There are no NOOPs.
- Assert rst160MHz for 1 cycle at bit 7 of a user frame -> cmd_out=0 next cycle. The truncated frame is not resent; the first slot after release is 0x817E.
- Send user frame 0x817E -> serial pattern matches sync, sync_sent stays 0, and the auto-sync cadence is unchanged.
- With RD53_CMD_STATS_EN: 10 user frames over 2×SYNC_PERIOD slots -> stat_user_cnt=10, stat_sync_cnt=2, stat_noop_cnt=52. Then pulse stat_clr -> all counters read 0 next cycle.
